// File: rtl/seg7_pkg.sv
// Shared FSM state encoding and 7-segment glyph constants for the value display.
package seg7_pkg;

  typedef enum logic [2:0] {
    CAPTURE = 3'd0,
    CONVERT = 3'd1,
    SIGN    = 3'd2,
    HUND    = 3'd3,
    TENS    = 3'd4,
    ONES    = 3'd5,
    GAP     = 3'd6,
    ERR     = 3'd7
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble: 10-bit unsigned to 3 BCD digits, one shift/add-3 step per clock.
module bin2bcd_iter
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [9:0]  shreg;
  logic [3:0]  steps_left;
  logic [11:0] bcd_adj;
  logic [21:0] shifted;

  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 3; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
    shifted = {bcd_adj, shreg} << 1;
  end

  // done is high during the cycle whose closing edge applies the tenth step.
  assign done = (steps_left == 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bcd        <= '0;
      steps_left <= '0;
    end else if (start) begin
      shreg      <= bin;
      bcd        <= '0;
      steps_left <= 4'd10;
    end else if (steps_left != 4'd0) begin
      bcd        <= shifted[21:10];
      shreg      <= shifted[9:0];
      steps_left <= steps_left - 4'd1;
    end
  end

endmodule

// File: rtl/seg7_value_display.sv
// Samples ans/error once per frame and cycles sign, hundreds, tens, ones and a gap on one 7-segment digit.
module seg7_value_display
  import seg7_pkg::*;
#(
  parameter int DWELL_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] ans,
  input  logic       error,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] dwell_cnt;
  logic          dwell_tc;
  logic          in_dwell;
  logic          neg;
  logic [9:0]    mag;
  logic [11:0]   bcd;
  logic          bcd_done;
  logic [6:0]    glyph;

  // 10'h200 negates to itself, which read as unsigned is the wanted 512.
  assign mag      = ans[9] ? (~ans + 10'd1) : ans;
  assign dwell_tc = (dwell_cnt == DW'(DWELL_CYCLES - 1));
  assign in_dwell = (state != CAPTURE) && (state != CONVERT);

  bin2bcd_iter u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (state == CAPTURE),
    .bin   (mag),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      CAPTURE: state_nxt = error ? ERR : CONVERT;
      CONVERT: if (bcd_done) state_nxt = SIGN;
      SIGN:    if (dwell_tc) state_nxt = HUND;
      HUND:    if (dwell_tc) state_nxt = TENS;
      TENS:    if (dwell_tc) state_nxt = ONES;
      ONES:    if (dwell_tc) state_nxt = GAP;
      GAP:     if (dwell_tc) state_nxt = CAPTURE;
      ERR:     if (dwell_tc) state_nxt = GAP;
      default: state_nxt = CAPTURE;
    endcase
  end

  always_comb begin
    glyph = SEG_BLANK;
    case (state)
      SIGN:    glyph = neg ? SEG_MINUS : SEG_BLANK;
      HUND:    glyph = bcd_to_seg(bcd[11:8]);
      TENS:    glyph = bcd_to_seg(bcd[7:4]);
      ONES:    glyph = bcd_to_seg(bcd[3:0]);
      ERR:     glyph = SEG_E;
      default: glyph = SEG_BLANK;
    endcase
  end

  // Outputs are registered from the current state, so they trail it by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CAPTURE;
      dwell_cnt   <= '0;
      neg         <= 1'b0;
      seg         <= SEG_BLANK;
      dp          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      if (state == CAPTURE) neg <= ans[9];
      if (in_dwell) dwell_cnt <= dwell_tc ? '0 : dwell_cnt + DW'(1);
      else          dwell_cnt <= '0;
      seg         <= glyph;
      dp          <= (state == ONES);
      frame_start <= (state == CAPTURE);
    end
  end

endmodule
